// File: rtl/fetch_responder_pkg.sv
// Shared widths and constants for the fetch path between PC, ROM and decode.
package fetch_responder_pkg;
    localparam int ROM_ADDR_W = 6;
    localparam int INST_W = 32;
    localparam int FETCH_DEPTH = 2;
    localparam logic [ROM_ADDR_W-1:0] RESET_ADDR = '0;
endpackage

// File: rtl/fetch_responder_if.sv
// Fetch-to-decode handshake: {addr, inst} offered with valid, taken with ready.
interface fetch_responder_if
    import fetch_responder_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = INST_W
);
    logic              instValid;
    logic              instReady;
    logic [ADDR_W-1:0] instAddr;
    logic [DATA_W-1:0] instData;

    modport master (
        output instValid,
        output instAddr,
        output instData,
        input  instReady
    );

    modport slave (
        input  instValid,
        input  instAddr,
        input  instData,
        output instReady
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push/pop, whole-queue clear and occupancy count.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 38
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

    // Credit upstream guarantees a full FIFO never sees a push.
    always_ff @(posedge clk) begin
        if (!rst && !clear) assert (!(push && count == CW'(DEPTH)));
    end
endmodule

// File: rtl/fetch_responder.sv
// ROM-side fetch responder: credit-based issue, in-flight tracking, buffered
// delivery to decode and jump flush.
module fetch_responder
    import fetch_responder_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = INST_W,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic              clk,
    input  logic              resetIn,
    input  logic [ADDR_W-1:0] addrIn,
    input  logic              flush,
    output logic              pcEnable,
    output logic              romEn,
    output logic [ADDR_W-1:0] romAddr,
    input  logic [DATA_W-1:0] romData,
    fetch_responder_if.master dec
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 2;

    logic [PW:0]          count;
    logic                 infV;
    logic [ADDR_W-1:0]    infAddr;
    logic                 valid;
    logic                 pop;
    logic                 push;
    logic                 issue;
    logic [CW-1:0]        need;
    logic [ADDR_W+DATA_W-1:0] head;

    assign valid = (count != '0);
    assign pop   = valid & dec.instReady;
    assign push  = infV & ~flush;

    // Slots committed after this cycle; pop frees one immediately.
    assign need  = CW'(count) + CW'(infV) - CW'(pop);
    assign issue = ~resetIn & ~flush & (need < CW'(DEPTH));

    assign romEn    = issue;
    assign romAddr  = addrIn;
    assign pcEnable = issue | (flush & ~resetIn);

    always_ff @(posedge clk) begin
        if (resetIn) infV <= 1'b0;
        else         infV <= issue;
        if (issue) infAddr <= addrIn;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (resetIn),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({infAddr, romData}),
        .rdata (head),
        .count (count)
    );

    assign dec.instValid = valid;
    assign dec.instAddr  = head[ADDR_W+DATA_W-1:DATA_W];
    assign dec.instData  = head[DATA_W-1:0];
endmodule

// File: tb/tb_fetch_responder.sv
// Bench for fetch_responder: directed vector table plus randomized scoreboard.
module tb_fetch_responder;
    import fetch_responder_pkg::*;

    localparam int AW = ROM_ADDR_W;
    localparam int DW = INST_W;
    localparam bit O = 1'b0;
    localparam bit I = 1'b1;

    typedef struct {
        bit          rst;
        bit          fl;
        bit          rdy;
        bit          ev;
        logic [5:0]  ea;
        bit          epe;
        bit          ere;
        logic [5:0]  epc;
    } vec_t;

    logic          clk = 1'b0;
    logic          resetIn;
    logic          flush;
    logic          pcEnable;
    logic          romEn;
    logic [AW-1:0] addrIn;
    logic [AW-1:0] romAddr;
    logic [AW-1:0] target;
    logic [DW-1:0] romData;
    logic [DW-1:0] rom [64];

    int n_chk = 0;
    int n_fail = 0;

    fetch_responder_if #(.ADDR_W(AW), .DATA_W(DW)) dec ();

    fetch_responder #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (2)
    ) dut (
        .clk      (clk),
        .resetIn  (resetIn),
        .addrIn   (addrIn),
        .flush    (flush),
        .pcEnable (pcEnable),
        .romEn    (romEn),
        .romAddr  (romAddr),
        .romData  (romData),
        .dec      (dec)
    );

    always #5 clk = ~clk;

    // PC and synchronous ROM models.
    always @(posedge clk) begin
        if (resetIn)       addrIn <= RESET_ADDR;
        else if (pcEnable) addrIn <= flush ? target : addrIn + 6'd1;
        if (romEn) romData <= rom[romAddr];
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(bit r, bit f, bit y, logic [5:0] tgt);
        @(posedge clk);
        #1;
        resetIn = r;
        flush = f;
        dec.instReady = y;
        target = tgt;
        @(negedge clk);
    endtask

    function automatic vec_t v(bit r, bit f, bit y, bit ev, logic [5:0] ea,
                               bit pe, bit re, logic [5:0] pc);
        vec_t t;
        t.rst = r; t.fl = f; t.rdy = y; t.ev = ev;
        t.ea = ea; t.epe = pe; t.ere = re; t.epc = pc;
        return t;
    endfunction

    vec_t tbl [22];
    logic [AW-1:0] exp_next;
    bit prev_fl;
    int pops;

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + 32'(i);
        resetIn = 1'b1;
        flush = 1'b0;
        dec.instReady = 1'b0;
        target = 6'h20;

        //         rst fl rdy  ev  addr   pe re  pc
        tbl[0]  = v(I, O, O,   O, 6'h00, O, O, 6'h00);
        tbl[1]  = v(O, O, I,   O, 6'h00, I, I, 6'h00);
        tbl[2]  = v(O, O, I,   O, 6'h00, I, I, 6'h01);
        tbl[3]  = v(O, O, O,   I, 6'h00, O, O, 6'h02);
        tbl[4]  = v(O, O, O,   I, 6'h00, O, O, 6'h02);
        tbl[5]  = v(O, O, O,   I, 6'h00, O, O, 6'h02);
        tbl[6]  = v(O, O, I,   I, 6'h00, I, I, 6'h02);
        tbl[7]  = v(O, O, I,   I, 6'h01, I, I, 6'h03);
        tbl[8]  = v(O, O, I,   I, 6'h02, I, I, 6'h04);
        tbl[9]  = v(O, O, O,   I, 6'h03, O, O, 6'h05);
        tbl[10] = v(O, I, O,   I, 6'h03, I, O, 6'h05);
        tbl[11] = v(O, O, I,   O, 6'h00, I, I, 6'h20);
        tbl[12] = v(O, O, I,   O, 6'h00, I, I, 6'h21);
        tbl[13] = v(O, O, I,   I, 6'h20, I, I, 6'h22);
        tbl[14] = v(O, I, I,   I, 6'h21, I, O, 6'h23);
        tbl[15] = v(O, O, I,   O, 6'h00, I, I, 6'h20);
        tbl[16] = v(O, O, I,   O, 6'h00, I, I, 6'h21);
        tbl[17] = v(O, O, O,   I, 6'h20, O, O, 6'h22);
        tbl[18] = v(I, O, O,   I, 6'h20, O, O, 6'h22);
        tbl[19] = v(O, O, I,   O, 6'h00, I, I, 6'h00);
        tbl[20] = v(O, O, I,   O, 6'h00, I, I, 6'h01);
        tbl[21] = v(O, O, I,   I, 6'h00, I, I, 6'h02);

        repeat (2) @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].rst, tbl[i].fl, tbl[i].rdy, 6'h20);
            chk($sformatf("vec%0d valid", i), 32'(dec.instValid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d pcEnable", i), 32'(pcEnable), 32'(tbl[i].epe));
            chk($sformatf("vec%0d romEn", i), 32'(romEn), 32'(tbl[i].ere));
            chk($sformatf("vec%0d romAddr", i), 32'(romAddr), 32'(tbl[i].epc));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d instAddr", i), 32'(dec.instAddr), 32'(tbl[i].ea));
                chk($sformatf("vec%0d instData", i), dec.instData,
                    32'h1000_0000 + 32'(tbl[i].ea));
            end
        end

        // Randomized run: scoreboard tracks the next expected address.
        drive(1'b1, 1'b0, 1'b0, 6'h00);
        chk("rand reset pcEnable", 32'(pcEnable), 32'(0));
        exp_next = RESET_ADDR;
        prev_fl = 1'b0;
        pops = 0;
        for (int c = 0; c < 1000; c++) begin
            drive(1'b0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                  6'($urandom));
            if (prev_fl) chk("rand valid after flush", 32'(dec.instValid), 32'(0));
            if (flush) begin
                chk("rand pcEnable in flush", 32'(pcEnable), 32'(1));
                chk("rand romEn in flush", 32'(romEn), 32'(0));
            end
            if (dec.instValid && dec.instReady) begin
                chk("rand seq addr", 32'(dec.instAddr), 32'(exp_next));
                chk("rand data", dec.instData, rom[dec.instAddr]);
                exp_next = dec.instAddr + 6'd1;
                pops++;
            end
            if (flush) exp_next = target;
            prev_fl = flush;
        end
        chk("rand progress", 32'(pops > 200), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
